// File: rtl/spm_bank.sv
// spm_bank -- parametrised dual-port scratchpad (IF port + MEM port).
//
// Ports:
//   clk, rst_          single clock, asynchronous active-low reset
//   ready              ports accept requests (registered FSM output)
//   wr_conflict        one-cycle pulse after both ports wrote the same word
//   if_spm_*           instruction-fetch port: addr, as_ (active-low strobe),
//                      rw (1=read, 0=write), be, wr_data, rd_data, rd_valid
//   mem_spm_*          memory-stage port, same signal set as the IF port
//
// Reads are registered: a request sampled at a rising edge drives rd_data /
// rd_valid in the following cycle. Writes become visible to any read sampled
// on a later edge. Same-edge collisions: the MEM port wins bytes both ports
// write. A read that hits the word the other port writes returns the merged
// new word (write-first).
//
// Optional feature: define SPM_INIT_CLEAR_EN to add a post-reset sweep that
// zeroes every word before ready rises. Without it, ready rises on the first
// edge after reset and array contents are undefined until written.

module spm_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_,
    output logic              ready,
    output logic              wr_conflict,

    input  logic [ADDR_W-1:0] if_spm_addr,
    input  logic              if_spm_as_,
    input  logic              if_spm_rw,
    input  logic [BE_W-1:0]   if_spm_be,
    input  logic [DATA_W-1:0] if_spm_wr_data,
    output logic [DATA_W-1:0] if_spm_rd_data,
    output logic              if_spm_rd_valid,

    input  logic [ADDR_W-1:0] mem_spm_addr,
    input  logic              mem_spm_as_,
    input  logic              mem_spm_rw,
    input  logic [BE_W-1:0]   mem_spm_be,
    input  logic [DATA_W-1:0] mem_spm_wr_data,
    output logic [DATA_W-1:0] mem_spm_rd_data,
    output logic              mem_spm_rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem_array [DEPTH];

`ifdef SPM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
`endif

    logic              if_rd, if_wr, mem_rd, mem_wr, same_addr;
    logic [DATA_W-1:0] if_rd_word, mem_rd_word;

    // Overlay the enabled bytes of wdata onto old.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        if_rd     = ready & ~if_spm_as_ &  if_spm_rw;
        if_wr     = ready & ~if_spm_as_ & ~if_spm_rw;
        mem_rd    = ready & ~mem_spm_as_ &  mem_spm_rw;
        mem_wr    = ready & ~mem_spm_as_ & ~mem_spm_rw;
        same_addr = (if_spm_addr == mem_spm_addr);
    end

    // Write-first forwarding: a read sees the other port's same-edge write.
    // A port cannot read and write in one cycle, so only the opposite port
    // can collide with a read.
    always_comb begin
        if_rd_word = mem_array[if_spm_addr];
        if (mem_wr && same_addr)
            if_rd_word = merge(if_rd_word, mem_spm_wr_data, mem_spm_be);
        mem_rd_word = mem_array[mem_spm_addr];
        if (if_wr && same_addr)
            mem_rd_word = merge(mem_rd_word, if_spm_wr_data, if_spm_be);
    end

    // Array storage: no reset. Per-byte write lanes, IF lane suppressed on
    // bytes the MEM port also writes to the same word.
    always_ff @(posedge clk) begin
`ifdef SPM_INIT_CLEAR_EN
        if (state == INIT) begin
            mem_array[clr_cnt] <= '0;
        end else
`endif
        begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (if_wr && if_spm_be[b] &&
                    !(mem_wr && mem_spm_be[b] && same_addr))
                    mem_array[if_spm_addr][b*8 +: 8] <= if_spm_wr_data[b*8 +: 8];
                if (mem_wr && mem_spm_be[b])
                    mem_array[mem_spm_addr][b*8 +: 8] <= mem_spm_wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read outputs and collision flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            if_spm_rd_data   <= '0;
            if_spm_rd_valid  <= 1'b0;
            mem_spm_rd_data  <= '0;
            mem_spm_rd_valid <= 1'b0;
            wr_conflict      <= 1'b0;
        end else begin
            if_spm_rd_valid  <= if_rd;
            mem_spm_rd_valid <= mem_rd;
            if (if_rd)  if_spm_rd_data  <= if_rd_word;
            if (mem_rd) mem_spm_rd_data <= mem_rd_word;
            wr_conflict      <= if_wr & mem_wr & same_addr;
        end
    end

    // Two-state controller; ready is a registered copy of (state == RUN).
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= INIT;
            ready   <= 1'b0;
`ifdef SPM_INIT_CLEAR_EN
            clr_cnt <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
`ifdef SPM_INIT_CLEAR_EN
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
`else
                    state <= RUN;
                    ready <= 1'b1;
`endif
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_bank.sv
// tb_spm_bank -- self-checking bench for spm_bank (default 32-bit x 4K).
// A word-level model (associative array of written words) predicts every
// output each cycle; directed sequences add literal expectations.
// Honours SPM_INIT_CLEAR_EN the same way the design does.

module tb_spm_bank;

`ifdef SPM_INIT_CLEAR_EN
    localparam int READY_EDGES = 4096;
`else
    localparam int READY_EDGES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_;
    logic        ready, wr_conflict;
    logic [11:0] if_addr, mem_addr;
    logic        if_as_, if_rw, mem_as_, mem_rw;
    logic [3:0]  if_be, mem_be;
    logic [31:0] if_wd, mem_wd, if_rd, mem_rd;
    logic        if_v, mem_v;

    int checks   = 0;
    int failures = 0;

    spm_bank #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk(clk), .rst_(rst_), .ready(ready), .wr_conflict(wr_conflict),
        .if_spm_addr(if_addr), .if_spm_as_(if_as_), .if_spm_rw(if_rw),
        .if_spm_be(if_be), .if_spm_wr_data(if_wd),
        .if_spm_rd_data(if_rd), .if_spm_rd_valid(if_v),
        .mem_spm_addr(mem_addr), .mem_spm_as_(mem_as_), .mem_spm_rw(mem_rw),
        .mem_spm_be(mem_be), .mem_spm_wr_data(mem_wd),
        .mem_spm_rd_data(mem_rd), .mem_spm_rd_valid(mem_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [int];
    logic [31:0] e_if_rd, e_mem_rd;
    bit          e_if_v, e_mem_v, e_conf, e_ready;
    int          edges;

    function automatic logic [31:0] mrd(input int a);
        if (mm.exists(a)) return mm[a];
`ifdef SPM_INIT_CLEAR_EN
        return 32'h0;
`else
        return 'x;
`endif
    endfunction

    function automatic void mwr(input int a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mrd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        mm[a] = w;
    endfunction

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            e_if_rd = '0; e_mem_rd = '0; e_if_v = 0; e_mem_v = 0;
            e_conf = 0; e_ready = 0; edges = 0;
            mm.delete();
        end else begin
            bit ia, ma;
            ia = e_ready && !if_as_;
            ma = e_ready && !mem_as_;
            // All writes of this edge land first (MEM after IF so MEM bytes win),
            // then reads see the resulting words.
            if (ia && !if_rw)  mwr(int'(if_addr), if_wd, if_be);
            if (ma && !mem_rw) mwr(int'(mem_addr), mem_wd, mem_be);
            e_conf  = ia && ma && !if_rw && !mem_rw && (if_addr == mem_addr);
            e_if_v  = ia && if_rw;
            e_mem_v = ma && mem_rw;
            if (e_if_v)  e_if_rd  = mrd(int'(if_addr));
            if (e_mem_v) e_mem_rd = mrd(int'(mem_addr));
            edges++;
            e_ready = (edges >= READY_EDGES);
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("ready",        ready,       e_ready);
        chk("wr_conflict",  wr_conflict, e_conf);
        chk("if_rd_valid",  if_v,        e_if_v);
        chk("mem_rd_valid", mem_v,       e_mem_v);
        if (!$isunknown(e_if_rd))  chk("if_rd_data",  if_rd,  e_if_rd);
        if (!$isunknown(e_mem_rd)) chk("mem_rd_data", mem_rd, e_mem_rd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        if_as_ = 1'b1; mem_as_ = 1'b1;
        if_rw = 1'b1; mem_rw = 1'b1;
        if_be = '0; mem_be = '0;
    endtask

    // Called at a negedge: present inputs, advance to the next negedge.
    task automatic req(input logic ias, input logic irw, input logic [11:0] ia,
                       input logic [3:0] ibe, input logic [31:0] id,
                       input logic mas, input logic mrw, input logic [11:0] ma,
                       input logic [3:0] mbe, input logic [31:0] md);
        if_as_ = ias; if_rw = irw; if_addr = ia; if_be = ibe; if_wd = id;
        mem_as_ = mas; mem_rw = mrw; mem_addr = ma; mem_be = mbe; mem_wd = md;
        @(negedge clk);
    endtask

    task automatic if_read(input logic [11:0] a);
        req(1'b0, 1'b1, a, 4'h0, '0, 1'b1, 1'b1, '0, 4'h0, '0);
    endtask

    task automatic mem_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        req(1'b1, 1'b1, '0, 4'h0, '0, 1'b0, 1'b0, a, be, d);
    endtask

    // Release reset mid-cycle and count edges until ready rises.
    task automatic release_and_wait(input string name);
        int n;
        @(negedge clk); #2 rst_ = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < READY_EDGES + 20) begin
            @(posedge clk); #1; n++;
        end
        chk(name, n, READY_EDGES);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   ready,       1'b0);
        chk({tag, "_conf"},    wr_conflict, 1'b0);
        chk({tag, "_if_rd"},   if_rd,       32'h0);
        chk({tag, "_mem_rd"},  mem_rd,      32'h0);
        chk({tag, "_if_v"},    if_v,        1'b0);
        chk({tag, "_mem_v"},   mem_v,       1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_addr = '0; mem_addr = '0; if_wd = '0; mem_wd = '0;
        idle();
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");

        // Post-reset readiness and clear.
        release_and_wait("ready_edges");
`ifdef SPM_INIT_CLEAR_EN
        if_read(12'hABC); idle();
        chk("clear_abc", if_rd, 32'h0000_0000);
        chk("clear_abc_v", if_v, 1'b1);
`endif

        // Fill 0..39 via MEM, read back-to-back via IF.
        for (int a = 0; a < 40; a++) mem_write(12'(a), 32'(a), 4'hF);
        idle();
        for (int a = 0; a < 40; a++) begin
            if_read(12'(a));
            chk("fill_valid", if_v, 1'b1);
            chk("fill_data", if_rd, 32'(a));
        end
        idle();
        @(negedge clk);
        chk("fill_valid_end", if_v, 1'b0);

        // Byte-enable merge.
        mem_write(12'd5, 32'h1122_3344, 4'hF);
        mem_write(12'd5, 32'hAABB_CCDD, 4'b0101);
        if_read(12'd5); idle();
        chk("be_merge", if_rd, 32'h11BB_33DD);

        // Write/write collision on address 7.
        req(1'b0, 1'b0, 12'd7, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 12'd7, 4'b0011, 32'h0);
        idle();
        chk("ww_conf_pulse", wr_conflict, 1'b1);
        if_read(12'd7); idle();
        chk("ww_conf_drop", wr_conflict, 1'b0);
        chk("ww_data", if_rd, 32'hFFFF_0000);

        // Read/write collision on address 9 (IF reads, MEM writes).
        mem_write(12'd9, 32'h0123_4567, 4'hF);
        req(1'b0, 1'b1, 12'd9, 4'h0, '0, 1'b0, 1'b0, 12'd9, 4'hF, 32'hDEAD_BEEF);
        idle();
        chk("rw_data", if_rd, 32'hDEAD_BEEF);
        chk("rw_valid", if_v, 1'b1);
        @(negedge clk);
        chk("idle_hold", if_rd, 32'hDEAD_BEEF);
        chk("idle_valid", if_v, 1'b0);

        // be = 0 is a no-op write.
        mem_write(12'd9, 32'h0000_0000, 4'h0);
        if_read(12'd9); idle();
        chk("be0_noop", if_rd, 32'hDEAD_BEEF);

        // Opposite direction collision: IF writes, MEM reads the same word.
        req(1'b0, 1'b0, 12'd11, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 12'd11, 4'h0, '0);
        idle();
        chk("wr_mem_rd", mem_rd, 32'h1234_5678);
        chk("wr_mem_rd_v", mem_v, 1'b1);

        // Reset while running / mid-sweep.
        @(negedge clk); #2 rst_ = 1'b0;
        #1 check_reset_outputs("rst_run");
        @(negedge clk); #2 rst_ = 1'b1;
`ifdef SPM_INIT_CLEAR_EN
        repeat (100) @(posedge clk);
        #2 rst_ = 1'b0;
        #1 check_reset_outputs("rst_mid");
`else
        @(posedge clk); #1;
        chk("rst_run_ready", ready, 1'b1);
        @(negedge clk); #2 rst_ = 1'b0;
        #1 check_reset_outputs("rst_again");
`endif
        release_and_wait("ready_edges_again");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spm_bank.md
# spm_bank

Parametrised dual-port scratchpad memory, successor to the fixed 4K×32 scratchpad. One port serves instruction fetch (`if_`) and the other serves the memory stage (`mem_`). The block adds configurable word width and depth, per-byte write enables, registered reads with a valid strobe, and defined same-address collision behaviour. An optional post-reset clear sweep is also available. It sits beside the pipeline's IF and MEM stages on the core's single clock.

## Interface
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, 12: word-address width; depth is `2**ADDR_W` words.
- `BE_W`, `DATA_W/8`: byte-enable width (derived; do not override).
- `clk` in 1: clock; all state updates on rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `ready` out 1: high when ports accept requests.
- `wr_conflict` out 1: one-cycle pulse when both ports write the same address in the same cycle.
- `if_spm_addr` in `ADDR_W`: IF port word address.
- `if_spm_as_` in 1: IF address strobe, active-low.
- `if_spm_rw` in 1: 1 = read, 0 = write.
- `if_spm_be` in `BE_W`: IF byte enables for writes.
- `if_spm_wr_data` in `DATA_W`: IF write data.
- `if_spm_rd_data` out `DATA_W`: IF read data (registered).
- `if_spm_rd_valid` out 1: IF read data valid, one-cycle pulse.
- `mem_spm_addr`, `mem_spm_as_`, `mem_spm_rw`, `mem_spm_be`, `mem_spm_wr_data`, `mem_spm_rd_data`, `mem_spm_rd_valid`: same as the IF port, for the MEM port.

## Operation
- **Request.** A request is sampled at a rising edge when `as_` = 0 and `ready` = 1. Requests with `ready` = 0 are dropped (no write, no valid).
- **Write.** Updates only the bytes whose `be` bit is 1. `be` = 0 is a legal no-op write.
- **Read.** Returns the full word; `be` is ignored.
- **Idle port.** With `as_` = 1, the port's `rd_data` holds its last value and `rd_valid` = 0.
- **Write/write collision** (both ports write the same address in the same cycle):
  - Per byte, the MEM port wins wherever its `be` bit is set.
  - IF-only bytes are still written.
  - `wr_conflict` pulses for 1 cycle.
- **Read/write collision** (one port reads the address the other writes in the same cycle): write-first. The read returns the merged new word.
- **Same-port behaviour.** A same-port read after a write in the previous cycle sees the new data.
- **State machine (2 states):**
  - `INIT`: entered on reset. Sweeps the clear counter from 0 to `2**ADDR_W-1`, writing 0 one word per cycle. `ready` = 0. Moves to `RUN` after the last word is written.
  - `RUN`: `ready` = 1 and normal operation. Leaves only on reset.
- **Reset mid-sweep.** An asserted `rst_` returns the FSM to `INIT` and restarts the counter at 0.

## Timing
- **Reset values:** `ready` 0, `wr_conflict` 0, both `rd_data` 0, both `rd_valid` 0, FSM `INIT`, clear counter 0. Array contents are not reset directly.
- **Read latency:** 1 cycle. For a request sampled at edge N, `rd_data` and `rd_valid` update at edge N+1.
- **Write latency:** effective at edge N, so a read sampled at edge N+1 returns the new data.
- **`wr_conflict`:** registered; asserted in the cycle after the colliding edge.
- **Back-to-back requests:** one request per port per cycle; the ports are fully independent apart from collisions.
- **Clear duration:** with the clear feature compiled in, `ready` rises `2**ADDR_W` edges after `rst_` deasserts (4096 at the default).

## Configuration
- **Macro:** `SPM_INIT_CLEAR_EN`.
- **Defined:** the `INIT` sweep runs as described, and all words read 0 after `ready` rises.
- **Undefined:**
  - There is no sweep and no clear counter. The FSM goes from `INIT` to `RUN` at the first rising edge after `rst_` deasserts, so `ready` = 1 from that edge on.
  - Array contents are undefined until written; a bench must not read unwritten words.

## Test plan
- **Post-reset readiness and clear.** Release `rst_`, then poll `ready`.
  - Macro defined: `ready` rises after 4096 edges, and a read of address 0xABC returns 0x00000000.
  - Macro undefined: `ready` rises after 1 edge.
- **Fill and readback.**
  - MEM port writes `data = addr` for addresses 0–39 with `be` = 4'hF.
  - IF port then reads 0–39 back to back. Each `rd_valid` pulse, 1 cycle after its request, carries 0x00000000 through 0x00000027.
- **Byte-enable merge.**
  - Write 0x11223344 to address 5, then write 0xAABBCCDD to address 5 with `be` = 4'b0101.
  - A read of address 5 returns 0x11BB33DD.
- **Write/write collision.**
  - Same cycle: IF writes 0xFFFFFFFF with `be` 4'hF and MEM writes 0x00000000 with `be` 4'b0011, both to address 7.
  - Address 7 then reads 0xFFFF0000, and `wr_conflict` pulses for exactly 1 cycle.
- **Read/write collision.** IF reads address 9 while MEM writes 0xDEADBEEF to address 9 in the same cycle. `if_spm_rd_data` = 0xDEADBEEF next cycle.
- **Reset mid-sweep** (macro defined). Assert `rst_` at sweep count 100 and release it. All outputs return to their reset values, and `ready` stays low for a full 4096 edges afterwards.
